// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the accumulator datapath.
// Sequences fetch/decode/execute one state per cycle, decodes Moore-style
// control outputs from the state register, and generates the post-reset
// register-clear window for the datapath registers.
module multicycle_controller #(
  parameter int INIT_CYCLES = 2,
  parameter bit CLEAR_MEM   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opc,
  output logic       pcSrc,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IRwrite,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       accSrc,
  output logic       ACCwrite,
  output logic       aluSrcA,
  output logic       aluSrcB,
  output logic [2:0] aluOp,
  output logic       rst_pc,
  output logic       rst_ir,
  output logic       rst_acc,
  output logic       rst_mdr,
  output logic       rst_aluReg,
  output logic       rst_dataMem,
  output logic       instr_done,
  output logic [3:0] state_dbg
);

  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_NOTA  = 3'b011;
  localparam logic [2:0] ALU_PASSA = 3'b100;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMRD  = 4'd3,
    EXEC   = 4'd4,
    EXNOT  = 4'd5,
    WBALU  = 4'd6,
    WBMEM  = 4'd7,
    MEMWR  = 4'd8,
    JUMP   = 4'd9,
    BRZ    = 4'd10
  } stateT;

  stateT            state;
  logic [CNT_W-1:0] initCnt;
  logic [2:0]       opcLatched;
  logic             rstAll;

  // State register, init-window counter and the opcode copy used by EXEC.
  // The opcode is latched in MEMRD so that later opc wiggles cannot disturb aluOp.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= INIT;
      initCnt    <= '0;
      opcLatched <= OP_ADD;
    end else begin
      case (state)
        INIT: begin
          if (initCnt == INIT_LAST) begin
            state   <= FETCH;
            initCnt <= '0;
          end else begin
            initCnt <= initCnt + CNT_W'(1);
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_LDA: state <= MEMRD;
            OP_NOT:                         state <= EXNOT;
            OP_STA:                         state <= MEMWR;
            OP_JMP:                         state <= JUMP;
            default:                        state <= BRZ;
          endcase
        end
        MEMRD: begin
          opcLatched <= opc;
          state      <= (opc == OP_LDA) ? WBMEM : EXEC;
        end
        EXEC, EXNOT:                   state <= WBALU;
        WBALU, WBMEM, MEMWR, JUMP, BRZ: state <= FETCH;
        default: begin
          state   <= INIT;
          initCnt <= '0;
        end
      endcase
    end
  end

  // Moore decode of the state register; a low rst overrides it in the same cycle so no write escapes.
  always_comb begin
    pcSrc       = 1'b0;
    IorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    IRwrite     = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    accSrc      = 1'b0;
    ACCwrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 1'b0;
    aluOp       = ALU_ADD;
    instr_done  = 1'b0;
    rstAll      = 1'b0;
    case (state)
      INIT: rstAll = 1'b1;
      FETCH: begin
        memRead = 1'b1;
        IRwrite = 1'b1;
        aluSrcB = 1'b1;
        pcSrc   = 1'b1;
        pcWrite = 1'b1;
      end
      MEMRD: begin
        memRead = 1'b1;
        IorD    = 1'b1;
      end
      EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = opcLatched;
      end
      EXNOT: begin
        aluSrcA = 1'b1;
        aluOp   = ALU_NOTA;
      end
      WBALU: begin
        ACCwrite   = 1'b1;
        instr_done = 1'b1;
      end
      WBMEM: begin
        accSrc     = 1'b1;
        ACCwrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        memWrite   = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pcWrite    = 1'b1;
        instr_done = 1'b1;
      end
      BRZ: begin
        aluSrcA     = 1'b1;
        aluOp       = ALU_PASSA;
        pcWriteCond = 1'b1;
        instr_done  = 1'b1;
      end
      default: ;
    endcase
    if (!rst) begin
      pcSrc       = 1'b0;
      IorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      IRwrite     = 1'b0;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      accSrc      = 1'b0;
      ACCwrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 1'b0;
      aluOp       = ALU_ADD;
      instr_done  = 1'b0;
      rstAll      = 1'b1;
    end
    rst_pc      = rstAll;
    rst_ir      = rstAll;
    rst_acc     = rstAll;
    rst_mdr     = rstAll;
    rst_aluReg  = rstAll;
    rst_dataMem = CLEAR_MEM & rstAll;
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model turns
// each opcode into its state path and per-cycle control expectations.
module tb_multicycle_controller;

  localparam int INIT_CYCLES = 2;
  localparam bit CLEAR_MEM   = 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opc;
  logic       pcSrc, IorD, memRead, memWrite, IRwrite, pcWrite, pcWriteCond;
  logic       accSrc, ACCwrite, aluSrcA, aluSrcB;
  logic [2:0] aluOp;
  logic       rst_pc, rst_ir, rst_acc, rst_mdr, rst_aluReg, rst_dataMem;
  logic       instr_done;
  logic [3:0] state_dbg;

  typedef struct packed {
    logic       pcSrc;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       accSrc;
    logic       accWrite;
    logic       aluSrcA;
    logic       aluSrcB;
    logic [2:0] aluOp;
    logic [5:0] rsts;
    logic       instrDone;
  } ctlT;

  typedef struct packed {
    logic [3:0] state;
    ctlT        ctl;
    ctlT        mask;
  } expT;

  expT sbQ[$];
  expT monExp;
  ctlT monAct;
  int  checks = 0;
  int  errors = 0;
  int  curState = 0;
  bit  monitorOn = 1'b0;

  multicycle_controller #(
    .INIT_CYCLES(INIT_CYCLES),
    .CLEAR_MEM  (CLEAR_MEM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opc        (opc),
    .pcSrc      (pcSrc),
    .IorD       (IorD),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .IRwrite    (IRwrite),
    .pcWrite    (pcWrite),
    .pcWriteCond(pcWriteCond),
    .accSrc     (accSrc),
    .ACCwrite   (ACCwrite),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .aluOp      (aluOp),
    .rst_pc     (rst_pc),
    .rst_ir     (rst_ir),
    .rst_acc    (rst_acc),
    .rst_mdr    (rst_mdr),
    .rst_aluReg (rst_aluReg),
    .rst_dataMem(rst_dataMem),
    .instr_done (instr_done),
    .state_dbg  (state_dbg)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Control expectations for one cycle spent in state s while executing opcode op.
  function automatic expT stateExp(input int s, input logic [2:0] op);
    expT e;
    e       = '0;
    e.state = 4'(s);
    e.mask  = '1;
    case (s)
      0: e.ctl.rsts = {5'h1f, CLEAR_MEM};
      1: begin
        e.ctl.memRead = 1'b1;
        e.ctl.irWrite = 1'b1;
        e.ctl.aluSrcB = 1'b1;
        e.ctl.pcSrc   = 1'b1;
        e.ctl.pcWrite = 1'b1;
      end
      3: begin
        e.ctl.memRead = 1'b1;
        e.ctl.iorD    = 1'b1;
      end
      4: begin
        e.ctl.aluSrcA = 1'b1;
        e.ctl.aluOp   = op;
      end
      5: begin
        e.ctl.aluSrcA = 1'b1;
        e.ctl.aluOp   = 3'b011;
      end
      6: begin
        e.ctl.accWrite  = 1'b1;
        e.ctl.instrDone = 1'b1;
      end
      7: begin
        e.ctl.accSrc    = 1'b1;
        e.ctl.accWrite  = 1'b1;
        e.ctl.instrDone = 1'b1;
      end
      8: begin
        e.ctl.iorD      = 1'b1;
        e.ctl.memWrite  = 1'b1;
        e.ctl.instrDone = 1'b1;
      end
      9: begin
        e.ctl.pcWrite   = 1'b1;
        e.ctl.instrDone = 1'b1;
      end
      10: begin
        e.ctl.aluSrcA     = 1'b1;
        e.ctl.aluOp       = 3'b100;
        e.ctl.pcWriteCond = 1'b1;
        e.ctl.instrDone   = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  // A cycle with rst low: enables forced off and clears asserted, whatever state the FSM sits in.
  function automatic expT resetExp(input int s);
    expT e;
    e                  = '0;
    e.state            = 4'(s);
    e.ctl.rsts         = {5'h1f, CLEAR_MEM};
    e.mask.memRead     = 1'b1;
    e.mask.memWrite    = 1'b1;
    e.mask.irWrite     = 1'b1;
    e.mask.pcWrite     = 1'b1;
    e.mask.pcWriteCond = 1'b1;
    e.mask.accWrite    = 1'b1;
    e.mask.rsts        = '1;
    return e;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue what that cycle must show.
  task automatic stepCycle(input logic r, input logic [2:0] o, input expT e);
    @(posedge clk);
    #1;
    rst = r;
    opc = o;
    sbQ.push_back(e);
  endtask

  // Hold reset, then walk through the clear window that precedes the first fetch.
  task automatic doReset(input int holdCycles);
    for (int i = 0; i < holdCycles; i++) begin
      stepCycle(1'b0, 3'($urandom), resetExp(curState));
      curState = 0;
    end
    for (int i = 0; i < INIT_CYCLES; i++) begin
      stepCycle(1'b1, 3'($urandom), stateExp(0, 3'd0));
    end
    curState = 1;
  endtask

  // Run one instruction; resetAt >= 0 aborts it with a reset at that cycle, glitch wiggles opc in EXEC.
  task automatic applyStimulus(input logic [2:0] op, input int resetAt, input bit glitch);
    int         path[$];
    int         s;
    logic [2:0] o;
    case (op)
      3'b000, 3'b001, 3'b010: path = {1, 2, 3, 4, 6};
      3'b011:                 path = {1, 2, 5, 6};
      3'b100:                 path = {1, 2, 3, 7};
      3'b101:                 path = {1, 2, 8};
      3'b110:                 path = {1, 2, 9};
      default:                path = {1, 2, 10};
    endcase
    foreach (path[k]) begin
      s        = path[k];
      curState = s;
      if (k == resetAt) begin
        doReset($urandom_range(1, 3));
        return;
      end
      o = (s == 2 || s == 3) ? op : 3'($urandom);
      stepCycle(1'b1, o, stateExp(s, op));
      if (glitch && s == 4) begin
        #2;
        opc = ~op;
        #4;
        opc = op ^ 3'b101;
      end
    end
    curState = 1;
  endtask

  // Compare one queued expectation against what the DUT presents this cycle.
  task automatic checkOutput();
    monExp             = sbQ.pop_front();
    monAct             = '0;
    monAct.pcSrc       = pcSrc;
    monAct.iorD        = IorD;
    monAct.memRead     = memRead;
    monAct.memWrite    = memWrite;
    monAct.irWrite     = IRwrite;
    monAct.pcWrite     = pcWrite;
    monAct.pcWriteCond = pcWriteCond;
    monAct.accSrc      = accSrc;
    monAct.accWrite    = ACCwrite;
    monAct.aluSrcA     = aluSrcA;
    monAct.aluSrcB     = aluSrcB;
    monAct.aluOp       = aluOp;
    monAct.rsts        = {rst_pc, rst_ir, rst_acc, rst_mdr, rst_aluReg, rst_dataMem};
    monAct.instrDone   = instr_done;
    checks++;
    if (state_dbg !== monExp.state) begin
      errors++;
      $display("[TB] FAIL state @%0t: state_dbg=%0d required=%0d", $time, state_dbg, monExp.state);
    end
    checks++;
    if ((monAct & monExp.mask) !== (monExp.ctl & monExp.mask)) begin
      errors++;
      $display("[TB] FAIL controls @%0t state=%0d: got=%h required=%h mask=%h",
               $time, monExp.state, monAct, monExp.ctl, monExp.mask);
    end
    checks++;
    if ((memRead && memWrite) || (pcWrite && pcWriteCond)) begin
      errors++;
      $display("[TB] FAIL exclusive @%0t: memRead=%b memWrite=%b pcWrite=%b pcWriteCond=%b required no pair high",
               $time, memRead, memWrite, pcWrite, pcWriteCond);
    end
  endtask

  // Monitor: on every falling edge pop the expectation for the current cycle and check it.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL underflow @%0t: queue size=0 required>0", $time);
      end else begin
        checkOutput();
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized instruction stream.
  initial begin
    rst       = 1'b0;
    opc       = 3'b000;
    curState  = 0;
    monitorOn = 1'b1;
    $display("[TB] multicycle_controller scoreboard bench start");
    doReset(3);
    applyStimulus(3'b000, -1, 1'b0);
    applyStimulus(3'b100, -1, 1'b0);
    applyStimulus(3'b101, -1, 1'b0);
    applyStimulus(3'b011, -1, 1'b0);
    applyStimulus(3'b110, -1, 1'b0);
    applyStimulus(3'b111, -1, 1'b0);
    applyStimulus(3'b101, 2, 1'b0);
    applyStimulus(3'b001, -1, 1'b1);
    applyStimulus(3'b010, -1, 1'b1);
    for (int n = 0; n < 160; n++) begin
      logic [2:0] op;
      int         ra;
      op = 3'($urandom);
      ra = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 2)) : -1;
      applyStimulus(op, ra, 1'($urandom));
    end
    @(negedge clk);
    #1;
    monitorOn = 1'b0;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: queue size=%0d required=0", sbQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
